// File: rtl/envelope_decay_scheduler.sv
// Time-multiplexed release-envelope engine: one voice advanced per clock per sample tick.
// Define ENV_EXP_DECAY_EN for an approximately exponential release; linear otherwise.

module envelope_voice #(
  parameter int AMP_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             note_on,
  input  logic             note_off,
  input  logic             proc,
  input  logic [7:0]       dt,
  output logic [AMP_W-1:0] amp,
  output logic             active
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DECAY = 2'd2;

  logic [1:0]       state;
  logic [7:0]       cnt;
  logic [8:0]       cnt_inc;
  logic [AMP_W-1:0] step_amp;

  assign cnt_inc = {1'b0, cnt} + 9'd1;

`ifdef ENV_EXP_DECAY_EN
  logic [AMP_W-1:0] sub;
  assign sub      = (amp >> 4) + AMP_W'(1);
  assign step_amp = (amp > sub) ? amp - sub : '0;
`else
  assign step_amp = (amp != '0) ? amp - AMP_W'(1) : '0;
`endif

  assign active = (state != S_IDLE);

  // Note events take priority over the sweep slot for this voice.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      amp   <= '0;
      cnt   <= '0;
    end else if (note_on) begin
      state <= S_HOLD;
      amp   <= '1;
      cnt   <= '0;
    end else if (note_off && state == S_HOLD) begin
      state <= S_DECAY;
      cnt   <= '0;
    end else if (proc && state == S_DECAY) begin
      if (dt == 8'd0) begin
        amp   <= '0;
        state <= S_IDLE;
        cnt   <= '0;
      end else if (cnt_inc >= {1'b0, dt}) begin
        cnt <= '0;
        amp <= step_amp;
        if (step_amp == '0) state <= S_IDLE;
      end else begin
        cnt <= cnt_inc[7:0];
      end
    end
  end
endmodule

module envelope_decay_scheduler #(
  parameter int NUM_VOICES = 8,
  parameter int AMP_W      = 8,
  parameter int IDX_W      = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [7:0]                  decay_time,
  input  logic                        sample_tick,
  input  logic [NUM_VOICES-1:0]       note_on,
  input  logic [NUM_VOICES-1:0]       note_off,
  output logic [NUM_VOICES*AMP_W-1:0] amp_out,
  output logic [NUM_VOICES-1:0]       voice_active,
  output logic                        busy,
  output logic                        sweep_done,
  output logic                        tick_overrun
);
  logic [IDX_W-1:0] idx;
  logic [7:0]       dt_l;
  logic             pending;
  logic             start;

  assign start = !busy && (sample_tick || pending);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx          <= '0;
      dt_l         <= '0;
      pending      <= 1'b0;
      busy         <= 1'b0;
      sweep_done   <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      if (start) begin
        dt_l <= decay_time;
        idx  <= '0;
        busy <= 1'b1;
        // A fresh tick alongside a pending one stays queued for the next sweep.
        pending <= pending && sample_tick;
      end else if (busy) begin
        if (sample_tick) begin
          if (pending) tick_overrun <= 1'b1;
          else         pending      <= 1'b1;
        end
        idx <= idx + IDX_W'(1);
        if (idx == IDX_W'(NUM_VOICES - 1)) begin
          busy       <= 1'b0;
          sweep_done <= 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    envelope_voice #(.AMP_W(AMP_W)) u_voice (
      .clk      (clk),
      .reset_n  (reset_n),
      .note_on  (note_on[i]),
      .note_off (note_off[i]),
      .proc     (busy && idx == IDX_W'(i)),
      .dt       (dt_l),
      .amp      (amp_out[i*AMP_W +: AMP_W]),
      .active   (voice_active[i])
    );
  end
endmodule

// File: doc/envelope_decay_scheduler.md
Name: envelope_decay_scheduler

Overview:
- Time-multiplexed release-envelope engine for the polyphonic voices.
- Consumes the 8-bit decay_time setting written by software through the Avalon PIO.
- On each audio sample tick, sweeps all voices one per clock, advancing each voice's amplitude envelope.
- Outputs per-voice amplitudes to the voice mixer.

Parameters:
- NUM_VOICES, 8, number of voices swept; 2..64.
- AMP_W, 8, amplitude width per voice; max amplitude = 2^AMP_W-1.
- IDX_W, 3, voice index width; must satisfy 2^IDX_W >= NUM_VOICES.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- decay_time  in  8  release period in sample ticks per amplitude step; 0 = instant release.
- sample_tick  in  1  one-cycle pulse per audio sample.
- note_on  in  NUM_VOICES  per-voice one-cycle trigger pulse.
- note_off  in  NUM_VOICES  per-voice one-cycle release pulse.
- amp_out  out  NUM_VOICES*AMP_W  flattened amplitudes; voice i at [i*AMP_W +: AMP_W].
- voice_active  out  NUM_VOICES  1 while voice is in HOLD or DECAY.
- busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse after the last voice is processed.
- tick_overrun  out  1  sticky; set when a tick is lost; cleared only by reset.

Behaviour:
- Reset is asynchronous, active-low, on reset_n; clock is clk.
- Reset values: all amp_out 0, voice states IDLE, prescale counters 0, busy 0, sweep_done 0, tick_overrun 0, pending 0.
- Per-voice state machine has three states.
  - IDLE: amp = 0.
  - HOLD: amp = max.
  - DECAY: amp stepping down.
- Note events are applied at the clock edge where they are sampled, independent of the sweep.
  - note_on[i]: state <= HOLD, amp <= max, counter <= 0. Allowed from any state (retrigger).
  - note_off[i]: HOLD -> DECAY, counter <= 0. Ignored in IDLE or DECAY.
  - note_on and note_off on the same voice in the same cycle: note_on wins.
  - A note event on the voice being swept in that same cycle overrides the sweep update for that voice.
- Sweep start: sample_tick sampled with busy=0, or a pending tick with busy=0.
  - On that edge: latch decay_time into dt_l, idx <= 0, busy <= 1.
  - Later changes to decay_time do not affect the current sweep.
- Sweep processing: on each edge with busy=1, process voice idx, then idx <= idx+1.
  - On the edge that processes voice NUM_VOICES-1: busy <= 0, sweep_done <= 1 for one cycle.
  - Voice i is updated at the (i+1)-th edge after the start edge.
  - Sweep latency: NUM_VOICES cycles.
- Voice processing applies only in DECAY; IDLE and HOLD are unchanged.
  - dt_l == 0: amp <= 0, state <= IDLE.
  - Else if counter+1 >= dt_l: counter <= 0, amp steps down (step rule below).
  - Else: counter <= counter+1.
  - If the new amp is 0: state <= IDLE, counter <= 0.
- Tick arriving while busy=1: pending <= 1, and a new sweep starts on the edge after busy falls.
- Tick arriving while busy=1 and pending=1: tick dropped, tick_overrun <= 1.
- Tick arriving on the same edge busy falls: treated as a busy tick (sets pending).
- Arithmetic: amp saturates at 0 and never wraps. The counter is 8 bits; compare uses 9-bit counter+1.
- voice_active[i] = (state != IDLE), registered with the state.
- Reset asserted mid-sweep aborts the sweep immediately; all state returns to reset values.

Optional Feature:
- Macro ENV_EXP_DECAY_EN.
- Defined: decay step is amp <= amp - (amp >> 4) - 1, saturating at 0, giving an approximately exponential release.
- Undefined: decay step is amp <= amp - 1 (linear).
- Timing, sweep and handshake behaviour are identical in both builds.

Test Plan:
- Reset, then idle 20 cycles -> amp_out all 0, busy 0, voice_active 0, tick_overrun 0.
- note_on[0], sample_tick -> amp0 = 255 one cycle after note_on. busy high for exactly 8 cycles; sweep_done pulses once; amp0 stays 255 (HOLD).
- Linear build, decay_time=3, note_on[2] then note_off[2], then 6 ticks spaced 20 cycles apart -> amp2 = 254 after tick 3, 253 after tick 6. voice_active[2] falls after 765 ticks.
- decay_time=0, voice 5 in HOLD, note_off[5], one tick -> amp5 = 0 and voice_active[5]=0 after voice 5's slot in that sweep.
- Tick at start of sweep, second tick mid-sweep, third tick mid-sweep -> second sweep starts the cycle after busy falls; third tick is dropped; tick_overrun = 1 and stays 1.
- Voice 1 in DECAY at amp 100; note_on[1] and note_off[1] in the same cycle as voice 1's sweep slot -> amp1 = 255, state HOLD. Exp build, dt=1, amp 255 -> next tick amp 239.
